// File: rtl/big_mux_stream_if.sv
// big_mux_stream_if: lane-side and output-side signals of the stream multiplexer.
//   in/in_valid/in_ack : packed lane data, per-lane request, one-hot acknowledge
//   mode/sel           : 0 = fixed lane sel, 1 = round-robin scan
//   out/out_sel/out_valid/out_ready : registered word, its lane index, handshake
interface big_mux_stream_if #(
   parameter int WIDTH = 4,
   parameter int SELW  = 8
);
   localparam int CH = 1 << SELW;
   logic [CH*WIDTH-1:0] in;
   logic [CH-1:0]       in_valid;
   logic [CH-1:0]       in_ack;
   logic                mode;
   logic [SELW-1:0]     sel;
   logic [WIDTH-1:0]    out;
   logic [SELW-1:0]     out_sel;
   logic                out_valid;
   logic                out_ready;
   modport master (output in, in_valid, mode, sel, out_ready,
                   input  in_ack, out, out_sel, out_valid);
   modport slave  (input  in, in_valid, mode, sel, out_ready,
                   output in_ack, out, out_sel, out_valid);
endinterface

// File: rtl/big_mux_stream.sv
// big_mux_stream: picks one of 2**SELW lanes (fixed select or round-robin) into a one-word output register.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : big_mux_stream_if slave (lane inputs, acknowledge, registered output stream)
module big_mux_stream #(
   parameter int WIDTH = 4,
   parameter int SELW  = 8
) (
   input logic           clk,
   input logic           reset,
   big_mux_stream_if.slave bus
);
   localparam int CH = 1 << SELW;
   logic [SELW-1:0] ptr, rr_off, g;
   logic [CH-1:0]   rot;
   logic            rr_hit, load, grant;
   // Rotating the request vector by ptr turns the wrapped search into a plain lowest-bit search.
   always_comb begin
      rot    = CH'({bus.in_valid, bus.in_valid} >> ptr);
      rr_hit = 1'b0;
      rr_off = '0;
      for (int i = CH - 1; i >= 0; i--) begin
         if (rot[i]) begin
            rr_hit = 1'b1;
            rr_off = SELW'(i);
         end
      end
   end
   assign load       = !bus.out_valid || bus.out_ready;
   assign g          = bus.mode ? ptr + rr_off : bus.sel;
   assign grant      = !reset && load && (bus.mode ? rr_hit : bus.in_valid[bus.sel]);
   assign bus.in_ack = grant ? (CH'(1) << g) : '0;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.out       <= '0;
         bus.out_sel   <= '0;
         bus.out_valid <= 1'b0;
         ptr           <= '0;
      end else if (load) begin
         bus.out_valid <= grant;
         if (grant) begin
            bus.out     <= bus.in[g*WIDTH +: WIDTH];
            bus.out_sel <= g;
            if (bus.mode) ptr <= g + SELW'(1);
         end
      end
   end
endmodule

// File: tb/tb_big_mux_stream.sv
// tb_big_mux_stream: directed table, hand sequences and randomized parameter sweep for big_mux_stream.
module tb_big_mux_stream;
   logic clk = 1'b0;
   logic rm;
   int   npass = 0, ntot = 0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [299:0] act, input logic [299:0] exp);
      ntot++;
      if (act !== exp) $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      else npass++;
   endtask

   big_mux_stream_if #(.WIDTH(4), .SELW(8)) m();
   big_mux_stream #(.WIDTH(4), .SELW(8)) dut (.clk(clk), .reset(rm), .bus(m));

   typedef struct {
      logic [7:0] sel;
      logic [7:0] vlane;
      logic       vbit;
      logic [3:0] data;
      logic       ready;
      logic       e_ack;
      logic [3:0] e_out;
      logic [7:0] e_sel;
      logic       e_valid;
   } vec_t;
   vec_t tbl[7];
   logic [3:0] eo;
   logic [7:0] es;

   task automatic noise();
      for (int i = 0; i < 256; i++) m.in[i*4 +: 4] = 4'($urandom);
   endtask

   task automatic step(input logic md, input logic [7:0] s, input logic [255:0] v, input logic rdy,
                       input int eg, input logic ev, input string nm);
      logic [255:0] ea;
      m.mode = md; m.sel = s; m.in_valid = v; m.out_ready = rdy;
      noise();
      #1;
      ea = '0;
      if (eg >= 0) ea[eg] = 1'b1;
      chk({nm, "_ack"}, m.in_ack, ea);
      if (eg >= 0) begin
         eo = m.in[eg*4 +: 4];
         es = eg[7:0];
      end
      @(negedge clk);
      chk({nm, "_out"}, {m.out, m.out_sel, m.out_valid}, {eo, es, ev});
   endtask

   for (genvar k = 0; k < 2; k++) begin : sw
      localparam int W = (k == 0) ? 1 : 16;
      localparam int S = (k == 0) ? 2 : 4;
      localparam int C = 1 << S;
      logic rs;
      logic fin = 1'b0;
      big_mux_stream_if #(.WIDTH(W), .SELW(S)) b();
      big_mux_stream #(.WIDTH(W), .SELW(S)) u (.clk(clk), .reset(rs), .bus(b));
      initial begin
         int ptr, g;
         logic [W-1:0] xo;
         logic [S-1:0] xs;
         logic xv, ld, dense;
         logic [C-1:0] ea;
         rs = 1'b1; b.in = '0; b.in_valid = '0; b.mode = 1'b0; b.sel = '0; b.out_ready = 1'b0;
         ptr = 0; xo = '0; xs = '0; xv = 1'b0;
         @(negedge clk);
         rs = 1'b0;
         repeat (400) begin
            chk("sweep_out", {b.out, b.out_sel, b.out_valid}, {xo, xs, xv});
            b.mode = 1'($urandom); b.sel = S'($urandom); b.out_ready = $urandom_range(3) != 0;
            dense = 1'($urandom);
            for (int i = 0; i < C; i++) begin
               b.in_valid[i] = dense ? 1'($urandom) : ($urandom_range(7) == 0);
               b.in[i*W +: W] = W'($urandom);
            end
            #1;
            ld = !xv || b.out_ready;
            g = -1;
            if (ld) begin
               if (b.mode) begin
                  for (int j = 0; j < C; j++)
                     if (g < 0 && b.in_valid[(ptr + j) % C]) g = (ptr + j) % C;
               end else if (b.in_valid[b.sel]) g = int'(b.sel);
            end
            ea = '0;
            if (g >= 0) ea[g] = 1'b1;
            chk("sweep_ack", b.in_ack, ea);
            chk("sweep_onehot", $countones(b.in_ack) <= 1, 1'b1);
            if (ld) begin
               xv = g >= 0;
               if (g >= 0) begin
                  xo = b.in[g*W +: W];
                  xs = g[S-1:0];
                  if (b.mode) ptr = (g + 1) % C;
               end
            end
            @(negedge clk);
         end
         fin = 1'b1;
      end
   end

   initial begin
      logic [255:0] v;
      logic [255:0] ea;
      tbl[0] = '{8'd37,  8'd37,  1, 4'hA, 1, 1, 4'hA, 8'd37,  1};
      tbl[1] = '{8'd5,   8'd6,   1, 4'h2, 1, 0, 4'hA, 8'd37,  0};
      tbl[2] = '{8'd255, 8'd255, 1, 4'hF, 1, 1, 4'hF, 8'd255, 1};
      tbl[3] = '{8'd0,   8'd0,   1, 4'h3, 0, 0, 4'hF, 8'd255, 1};
      tbl[4] = '{8'd0,   8'd0,   1, 4'h3, 1, 1, 4'h3, 8'd0,   1};
      tbl[5] = '{8'd128, 8'd128, 0, 4'h9, 1, 0, 4'h3, 8'd0,   0};
      tbl[6] = '{8'd128, 8'd128, 1, 4'h7, 0, 1, 4'h7, 8'd128, 1};
      rm = 1'b1; m.mode = 1'b0; m.sel = 8'd37; m.in_valid = '1; m.out_ready = 1'b1;
      noise();
      #1;
      chk("reset_ack", m.in_ack, 256'd0);
      chk("reset_out", {m.out, m.out_sel, m.out_valid}, 13'd0);
      @(negedge clk);
      chk("reset_hold", {m.out, m.out_sel, m.out_valid}, 13'd0);
      rm = 1'b0;
      foreach (tbl[t]) begin
         noise();
         m.mode = 1'b0; m.sel = tbl[t].sel; m.out_ready = tbl[t].ready;
         m.in_valid = '0;
         m.in_valid[tbl[t].vlane] = tbl[t].vbit;
         m.in[tbl[t].vlane*4 +: 4] = tbl[t].data;
         #1;
         ea = '0;
         ea[tbl[t].vlane] = tbl[t].e_ack;
         chk($sformatf("tbl%0d_ack", t), m.in_ack, ea);
         @(negedge clk);
         chk($sformatf("tbl%0d_out", t), {m.out, m.out_sel, m.out_valid},
             {tbl[t].e_out, tbl[t].e_sel, tbl[t].e_valid});
      end
      eo = 4'h7; es = 8'd128;
      for (int i = 0; i < 3; i++) step(1'b0, 8'($urandom), '1, 1'b0, -1, 1'b1, "stall");
      step(1'b0, 8'd99, '1, 1'b1, 99, 1'b1, "unstall");
      #2 rm = 1'b1;
      @(negedge clk);
      rm = 1'b0; eo = '0; es = '0;
      v = '0; v[3] = 1; v[200] = 1; v[255] = 1;
      step(1'b1, 8'd0, v, 1'b1, 3,   1'b1, "rr_a");
      step(1'b1, 8'd0, v, 1'b1, 200, 1'b1, "rr_b");
      step(1'b1, 8'd0, v, 1'b1, 255, 1'b1, "rr_c");
      step(1'b1, 8'd0, v, 1'b1, 3,   1'b1, "rr_wrap");
      v = '0; v[200] = 1;
      step(1'b1, 8'd0, v, 1'b1, 200, 1'b1, "rr_200");
      step(1'b1, 8'd0, '0, 1'b1, -1, 1'b0, "rr_idle1");
      step(1'b1, 8'd0, '0, 1'b1, -1, 1'b0, "rr_idle2");
      v = '0; v[0] = 1;
      step(1'b1, 8'd0, v, 1'b1, 0, 1'b1, "rr_lane0");
      v[150] = 1;
      step(1'b1, 8'd0, v, 1'b1, 150, 1'b1, "rr_after0");
      v = '0; v[200] = 1;
      step(1'b1, 8'd0, v, 1'b1, 200, 1'b1, "pre_rst");
      #2 rm = 1'b1;
      #1;
      chk("async_rst_out", {m.out, m.out_sel, m.out_valid}, 13'd0);
      chk("async_rst_ack", m.in_ack, 256'd0);
      @(negedge clk);
      rm = 1'b0; eo = '0; es = '0;
      v = '0; v[5] = 1; v[250] = 1;
      step(1'b1, 8'd0, v, 1'b1, 5, 1'b1, "post_rst");
      for (int t = 0; t < 2000 && !(sw[0].fin && sw[1].fin); t++) @(negedge clk);
      chk("sweep_done", {sw[0].fin, sw[1].fin}, 2'b11);
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule

// File: doc/big_mux_stream.md
BIG_MUX_STREAM -- requirements
Module: big_mux_stream

Interface
REQ-001 Parameter: WIDTH, default 4, lane data width in bits (>=1).
REQ-002 Parameter: SELW, default 8, select width; lane count CH = 2**SELW (default 256).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: in  input  CH*WIDTH  packed lane data; lane i at bits [i*WIDTH +: WIDTH].
REQ-006 Port: in_valid  input  CH  per-lane request; bit i qualifies lane i.
REQ-007 Port: in_ack  output  CH  one-hot (or zero) combinational acknowledge; bit i high means lane i is captured on this edge.
REQ-008 Port: mode  input  1  0 = fixed select, 1 = round-robin scan.
REQ-009 Port: sel  input  SELW  lane index used in fixed mode.
REQ-010 Port: out  output  WIDTH  registered selected lane data.
REQ-011 Port: out_sel  output  SELW  lane index that produced out.
REQ-012 Port: out_valid  output  1  out/out_sel hold a valid word.
REQ-013 Port: out_ready  input  1  downstream accepts word when out_valid && out_ready.

Function
REQ-014 The block SHALL define load = !out_valid || out_ready; a capture is possible only in a load cycle.
REQ-015 In a non-load cycle (out_valid && !out_ready), out, out_sel, out_valid and the scan pointer SHALL hold and in_ack SHALL be all-zero.
REQ-016 Fixed mode, load cycle: if in_valid[sel], the block SHALL assert in_ack[sel] and on the edge set out = lane sel, out_sel = sel, out_valid = 1.
REQ-017 Fixed mode, load cycle, in_valid[sel] = 0: in_ack SHALL be zero and out_valid SHALL clear on the edge; out and out_sel SHALL hold.
REQ-018 Fixed mode SHALL NOT modify the scan pointer.
REQ-019 Round-robin mode, load cycle: the grant SHALL be the first lane g with in_valid[g] = 1 searching ptr, ptr+1, ... CH-1, 0, ... ptr-1 (wrap modulo CH).
REQ-020 On a round-robin grant the block SHALL assert in_ack[g], set out = lane g, out_sel = g, out_valid = 1, and ptr = (g+1) mod CH (g = CH-1 wraps ptr to 0).
REQ-021 Round-robin, load cycle, in_valid all-zero: in_ack zero, out_valid clears, ptr/out/out_sel hold.
REQ-022 Latency SHALL be one cycle from capture edge to out_valid; sustained throughput one word per cycle while out_ready = 1.
REQ-023 At most one in_ack bit SHALL be high in any cycle, and never outside a load cycle.
REQ-024 mode and sel SHALL be sampled only in load cycles; a change while stalled takes effect at the next load cycle.
REQ-025 out SHALL always equal exactly lane out_sel's data as sampled on the capture edge (no later lane changes visible).

Reset
REQ-026 While reset is high, independent of clk: out = 0, out_sel = 0, out_valid = 0, ptr = 0; in_ack SHALL be all-zero.
REQ-027 Reset asserted mid-transfer SHALL discard the held word; first capture after release SHALL follow REQ-016/REQ-019 with ptr = 0.

Verification
REQ-028 Fixed mode, sel = 8'd37, in_valid[37] = 1, lane 37 = 4'hA, out_ready = 1 -> in_ack[37] same cycle; next cycle out = 4'hA, out_sel = 37, out_valid = 1.
REQ-029 Stall: out_valid = 1, out_ready = 0 for 3 cycles while lane data and sel change -> out/out_sel constant, in_ack = 0 throughout; out_ready = 1 -> new capture next edge.
REQ-030 Round-robin, in_valid bits {3, 200, 255} all held high, out_ready = 1, ptr = 0 -> out_sel sequence 3, 200, 255, 3; ptr after 255 grant = 0.
REQ-031 Round-robin, in_valid all-zero for 2 load cycles -> out_valid = 0, ptr unchanged; then in_valid[0] = 1 only with ptr = 201 -> grant lane 0 (wrap).
REQ-032 Reset asserted asynchronously between edges with out_valid = 1 -> out_valid, out, out_sel drop to 0 immediately; after release round-robin grants start searching from lane 0.
REQ-033 Parameter sweep WIDTH = 1, SELW = 2 and WIDTH = 16, SELW = 4 -> random in_valid/out_ready/mode; scoreboard confirms REQ-019..REQ-025 and one-hot in_ack.
